// File: rtl/fifo_sched_if.sv
// Handshake bundle between fifo_sched, its producers/consumer and the 4x1 fifo.
// The scheduler connects through the slave modport; the environment uses the master modport.
interface fifo_sched_if #(
    parameter int CNT_W = 3
);
    logic             push_req_a;
    logic             din_a;
    logic             push_req_b;
    logic             din_b;
    logic             push_gnt_a;
    logic             push_gnt_b;
    logic             pop_req;
    logic             pop_gnt;
    logic             dout_valid;
    logic             dout;
    logic             flush_req;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             busy;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_clear;
    logic             fifo_i;
    logic             fifo_p;

    modport master (
        output push_req_a, din_a, push_req_b, din_b, pop_req, flush_req, fifo_p,
        input  push_gnt_a, push_gnt_b, pop_gnt, dout_valid, dout, count,
               full, empty, busy, fifo_push, fifo_pop, fifo_clear, fifo_i
    );

    modport slave (
        input  push_req_a, din_a, push_req_b, din_b, pop_req, flush_req, fifo_p,
        output push_gnt_a, push_gnt_b, pop_gnt, dout_valid, dout, count,
               full, empty, busy, fifo_push, fifo_pop, fifo_clear, fifo_i
    );
endinterface

// File: rtl/fifo_sched.sv
// Occupancy tracker, round-robin push arbiter and clear/flush sequencer for
// the flagless, resetless 4-entry 1-bit fifo.
module fifo_sched #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input logic         clk,
    input logic         reset,
    fifo_sched_if.slave bus
);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rrIsB_q, rrIsB_d;
    logic             doutValid_q;

    logic gntA, gntB, popGnt, clearFifo;
    logic isFull, isEmpty;

    assign isFull  = (count_q == CNT_W'(DEPTH));
    assign isEmpty = (count_q == '0);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rrIsB_d   = rrIsB_q;
        gntA      = 1'b0;
        gntB      = 1'b0;
        popGnt    = 1'b0;
        clearFifo = 1'b0;

        unique case (state_q)
            INIT: begin
                clearFifo = 1'b1;
                count_d   = '0;
                state_d   = RUN;
            end
            RUN: begin
                if (bus.flush_req) begin
                    state_d = FLUSH;
                end else begin
                    // The fifo pops before it pushes, so a granted pop frees a slot for a push when full.
                    popGnt = bus.pop_req & ~isEmpty;
                    if (~isFull | popGnt) begin
                        if (bus.push_req_a && (!bus.push_req_b || rrIsB_q)) begin
                            gntA = 1'b1;
                        end else if (bus.push_req_b) begin
                            gntB = 1'b1;
                        end
                    end
                    if (gntA) begin
                        rrIsB_d = 1'b0;
                    end else if (gntB) begin
                        rrIsB_d = 1'b1;
                    end
                    count_d = count_q + CNT_W'(gntA | gntB) - CNT_W'(popGnt);
                end
            end
            FLUSH: begin
                clearFifo = 1'b1;
                count_d   = '0;
                if (!bus.flush_req) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase

        // Reset kills grants immediately and keeps the fifo clearing while it is held.
        if (reset) begin
            gntA      = 1'b0;
            gntB      = 1'b0;
            popGnt    = 1'b0;
            clearFifo = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT;
            count_q     <= '0;
            rrIsB_q     <= 1'b1;
            doutValid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rrIsB_q     <= rrIsB_d;
            doutValid_q <= popGnt;
        end
    end

    assign bus.push_gnt_a = gntA;
    assign bus.push_gnt_b = gntB;
    assign bus.pop_gnt    = popGnt;
    assign bus.dout_valid = doutValid_q;
    assign bus.dout       = bus.fifo_p;
    assign bus.count      = count_q;
    assign bus.full       = isFull;
    assign bus.empty      = isEmpty;
    assign bus.busy       = (state_q != RUN);
    assign bus.fifo_push  = gntA | gntB;
    assign bus.fifo_pop   = popGnt;
    assign bus.fifo_clear = clearFifo;
    assign bus.fifo_i     = gntA ? bus.din_a : (gntB ? bus.din_b : 1'b0);

endmodule

// File: tb/tb_fifo_sched.sv
// Directed and random bench for fifo_sched with a queue-based reference model
// and a behavioural model of the physical fifo driving fifo_p.
module tb_fifo_sched;

    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;
    localparam int M_INIT = 0;
    localparam int M_RUN  = 1;
    localparam int M_FLSH = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fifo_sched_if #(.CNT_W(CNT_W)) bus ();

    fifo_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Physical fifo: no reset, starts with junk, pops before it pushes.
    bit   physQ[$] = '{1'b1, 1'b0, 1'b1};
    logic physP    = 1'b0;

    assign bus.fifo_p = physP;

    always @(posedge clk) begin
        if (bus.fifo_clear) begin
            physQ.delete();
        end else begin
            if (bus.fifo_pop) begin
                if (physQ.size() > 0) physP <= physQ.pop_front();
                else                  physP <= 1'bx;
            end
            if (bus.fifo_push && physQ.size() < DEPTH) physQ.push_back(bus.fifo_i);
        end
    end

    int checks = 0;
    int errors = 0;

    int mState = M_INIT;
    bit mQ[$];
    bit mRrB   = 1'b1;
    bit mValid = 1'b0;
    bit mDout  = 1'b0;

    bit lastGa, lastGb, lastPop;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit pa, input bit da, input bit pb,
                                 input bit db, input bit pr, input bit fl);
        reset          = rst;
        bus.push_req_a = pa;
        bus.din_a      = da;
        bus.push_req_b = pb;
        bus.din_b      = db;
        bus.pop_req    = pr;
        bus.flush_req  = fl;
    endtask

    task automatic checkOutput();
        bit eGa, eGb, ePop, eClr, eI;
        int n;
        eGa  = 1'b0;
        eGb  = 1'b0;
        ePop = 1'b0;
        eI   = 1'b0;
        #1;
        n    = mQ.size();
        eClr = reset || (mState != M_RUN);
        if (!reset && mState == M_RUN && !bus.flush_req) begin
            ePop = bus.pop_req && (n > 0);
            if (n < DEPTH || ePop) begin
                if (bus.push_req_a && bus.push_req_b) begin
                    eGa = mRrB;
                    eGb = !mRrB;
                end else begin
                    eGa = bus.push_req_a;
                    eGb = bus.push_req_b;
                end
            end
            eI = eGa ? bus.din_a : (eGb ? bus.din_b : 1'b0);
        end

        chk("push_gnt_a", 8'(bus.push_gnt_a), 8'(eGa));
        chk("push_gnt_b", 8'(bus.push_gnt_b), 8'(eGb));
        chk("pop_gnt",    8'(bus.pop_gnt),    8'(ePop));
        chk("fifo_push",  8'(bus.fifo_push),  8'(eGa | eGb));
        chk("fifo_pop",   8'(bus.fifo_pop),   8'(ePop));
        chk("fifo_clear", 8'(bus.fifo_clear), 8'(eClr));
        chk("fifo_i",     8'(bus.fifo_i),     8'(eI));
        chk("count",      8'(bus.count),      8'(n));
        chk("full",       8'(bus.full),       8'(n == DEPTH));
        chk("empty",      8'(bus.empty),      8'(n == 0));
        chk("busy",       8'(bus.busy),       8'(mState != M_RUN));
        chk("dout_valid", 8'(bus.dout_valid), 8'(mValid));
        if (mValid) chk("dout", 8'(bus.dout), 8'(mDout));

        lastGa  = eGa;
        lastGb  = eGb;
        lastPop = ePop;

        @(posedge clk);
        if (reset) begin
            mState = M_INIT;
            mQ.delete();
            mValid = 1'b0;
            mRrB   = 1'b1;
        end else begin
            case (mState)
                M_INIT: begin
                    mState = M_RUN;
                    mQ.delete();
                    mValid = 1'b0;
                end
                M_RUN: begin
                    if (bus.flush_req) begin
                        mState = M_FLSH;
                        mValid = 1'b0;
                    end else begin
                        mValid = ePop;
                        if (ePop) mDout = mQ.pop_front();
                        if (eGa) begin
                            mQ.push_back(bus.din_a);
                            mRrB = 1'b0;
                        end
                        if (eGb) begin
                            mQ.push_back(bus.din_b);
                            mRrB = 1'b1;
                        end
                    end
                end
                default: begin
                    mQ.delete();
                    mValid = 1'b0;
                    if (!bus.flush_req) mState = M_RUN;
                end
            endcase
        end
        @(negedge clk);
    endtask

    task automatic step(input bit rst, input bit pa, input bit da, input bit pb,
                        input bit db, input bit pr, input bit fl);
        applyStimulus(rst, pa, da, pb, db, pr, fl);
        checkOutput();
    endtask

    initial begin
        bit pa, pb, pr, fl, da, db, rs;
        bit s2Data[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);

        $display("[TB] scenario 1: reset and clear sequencing");
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("s1_busy_after_init", 8'(bus.busy), 8'd0);

        $display("[TB] scenario 2: A fills the fifo");
        for (int i = 0; i < 4; i++) step(0, 1, s2Data[i], 0, 0, 0, 0);
        chk("s2_count_full", 8'(bus.count), 8'd4);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1, 0);
        chk("s2_count_after_pop_push", 8'(bus.count), 8'd4);

        $display("[TB] scenario 3: drain the fifo");
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 0);
        chk("s3_empty", 8'(bus.empty), 8'd1);

        $display("[TB] scenario 4: A/B tie round-robin");
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1'(i), 1, 1'(~i), 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1'(i), 1, 0);

        $display("[TB] scenario 5: flush with pending traffic");
        step(0, 0, 0, 0, 0, 1, 0);
        chk("s5_count_before_flush", 8'(bus.count), 8'd3);
        step(0, 1, 1, 1, 0, 1, 1);
        step(0, 1, 1, 1, 0, 1, 1);
        step(0, 1, 1, 1, 0, 1, 0);
        chk("s5_count_after_flush", 8'(bus.count), 8'd0);
        step(0, 0, 0, 0, 0, 0, 0);

        $display("[TB] scenario 6: push and pop on an empty fifo");
        step(0, 1, 1, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 1, 0);
        chk("s6_count_steady", 8'(bus.count), 8'd1);
        step(0, 0, 0, 0, 0, 0, 0);

        $display("[TB] random traffic");
        pa = 0; pb = 0; pr = 0; fl = 0; da = 0; db = 0;
        for (int n = 0; n < 600; n++) begin
            if (!pa) begin
                pa = ($urandom_range(0, 2) != 0);
                da = 1'($urandom_range(0, 1));
            end
            if (!pb) begin
                pb = ($urandom_range(0, 2) != 0);
                db = 1'($urandom_range(0, 1));
            end
            if (!pr) pr = ($urandom_range(0, 1) != 0);
            fl = ($urandom_range(0, 19) == 0) || (fl && ($urandom_range(0, 1) != 0));
            rs = ($urandom_range(0, 99) == 0);
            step(rs, pa, da, pb, db, pr, fl);
            if (lastGa)  pa = 0;
            if (lastGb)  pb = 0;
            if (lastPop) pr = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
